sysarray_result_drain: RTL and testbench

- Downstream stage of the NUM x NUM systolic GEMM array.
- Captures each PE's one-cycle resultvalid/resultvalue pulse into a per-PE holding register.
- Once all NUM*NUM results of a tile are held, streams them out one row per beat (NUM words) over a valid/ready interface. The next tile is then accepted.

---
 rtl/sysarray_result_drain.sv | 102 ++++++++++
 tb/tb_sysarray_result_drain.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysarray_result_drain.sv
// Collects one result per PE of a NUM x NUM tile, then streams the tile out one row per beat.
// First beat is valid the cycle after the final capture; outready=0 holds the beat stable and later results are dropped.
module sysarray_result_drain #(
  parameter int WL  = 32,
  parameter int NUM = 16,
  parameter int RW  = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NUM*NUM-1:0]    resultvalid,
  input  logic [WL*NUM*NUM-1:0] resultvalue,
  output logic [WL*NUM-1:0]     outvalue,
  output logic [RW-1:0]         outrow,
  output logic                  outvalid,
  input  logic                  outready,
  output logic                  outlast,
  output logic                  busy,
  output logic                  overflow
);

  localparam int NPE = NUM * NUM;
  localparam logic [RW-1:0] LASTROW = RW'(NUM - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [NPE-1:0]   captured, cap_base, hit, take, captured_nxt;
  logic [WL-1:0]    hold [NUM][NUM];
  logic [RW-1:0]    row;
  logic             fire, final_fire;

  assign fire       = (state == DRAIN) && outready;
  assign final_fire = fire && (row == LASTROW);
  assign outrow     = row;

  // On the final handshake the flags clear first, so a pulse on that edge starts the next tile.
  always_comb begin
    cap_base     = final_fire ? '0 : captured;
    hit          = ena ? resultvalid : '0;
    take         = hit & ~cap_base;
    captured_nxt = cap_base | take;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    outvalid  = 1'b0;
    busy      = 1'b0;
    outlast   = 1'b0;
    case (state)
      COLLECT: begin
        if (&captured_nxt) state_nxt = DRAIN;
      end
      DRAIN: begin
        outvalid = 1'b1;
        busy     = 1'b1;
        outlast  = (row == LASTROW);
        if (final_fire) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      captured <= '0;
      row      <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        for (int j = 0; j < NUM; j++) begin
          hold[i][j] <= '0;
        end
      end
    end else begin
      captured <= captured_nxt;
      if (|(hit & cap_base)) overflow <= 1'b1;
      if (fire) row <= final_fire ? '0 : row + RW'(1);
      for (int i = 0; i < NUM; i++) begin
        for (int j = 0; j < NUM; j++) begin
          if (take[i*NUM+j]) hold[i][j] <= resultvalue[(i*NUM+j)*WL +: WL];
        end
      end
    end
  end

  // Holding registers cannot change during DRAIN, so the beat stays stable under backpressure.
  always_comb begin
    outvalue = '0;
    for (int j = 0; j < NUM; j++) begin
      outvalue[j*WL +: WL] = hold[row][j];
    end
  end

endmodule

// File: tb/tb_sysarray_result_drain.sv
// Scoreboarded bench for sysarray_result_drain at NUM=2, WL=8.
module tb_sysarray_result_drain;

  localparam int WL  = 8;
  localparam int NUM = 2;
  localparam int RW  = 1;

  logic                  clk;
  logic                  rst;
  logic                  ena;
  logic [NUM*NUM-1:0]    resultvalid;
  logic [WL*NUM*NUM-1:0] resultvalue;
  logic [WL*NUM-1:0]     outvalue;
  logic [RW-1:0]         outrow;
  logic                  outvalid;
  logic                  outready;
  logic                  outlast;
  logic                  busy;
  logic                  overflow;

  typedef struct packed {
    logic [RW-1:0]     row;
    logic [WL*NUM-1:0] val;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  int    total  = 0;
  int    passed = 0;

  sysarray_result_drain #(.WL(WL), .NUM(NUM), .RW(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .resultvalid (resultvalid),
    .resultvalue (resultvalue),
    .outvalue    (outvalue),
    .outrow      (outrow),
    .outvalid    (outvalid),
    .outready    (outready),
    .outlast     (outlast),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m, input logic [31:0] v, input logic e);
    ena         = e;
    resultvalid = m;
    resultvalue = v;
    tick();
    resultvalid = '0;
    ena         = 1'b1;
  endtask

  task automatic push(input logic [RW-1:0] r, input logic [15:0] v, input logic l);
    beat_t b;
    b.row  = r;
    b.val  = v;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic wait_drained(input string name);
    for (int n = 0; n < 12 && exp_q.size() != 0; n++) tick();
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_idle_valid"}, outvalid, 0);
    chk({name, "_idle_busy"}, busy, 0);
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && outvalid && outready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got row %0d value %0h, expected no beat", outrow, outvalue);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_row", outrow, b.row);
        chk("beat_value", outvalue, b.val);
        chk("beat_last", outlast, b.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    ena         = 1'b1;
    resultvalid = '0;
    resultvalue = '0;
    outready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outvalid", outvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_outvalue", outvalue, 0);
    chk("rst_outrow", outrow, 0);
    chk("rst_outlast", outlast, 0);
    rst = 1'b1;
    tick();

    // Basic tile: all four PEs in one cycle
    push(1'b0, 16'h0201, 1'b0);
    push(1'b1, 16'h0403, 1'b1);
    pulse(4'b1111, 32'h04030201, 1'b1);
    chk("basic_valid", outvalid, 1);
    chk("basic_busy", busy, 1);
    wait_drained("basic");
    chk("basic_overflow", overflow, 0);

    // Staggered wavefront arrival
    push(1'b0, 16'h2211, 1'b0);
    push(1'b1, 16'h4433, 1'b1);
    pulse(4'b0001, 32'h44332211, 1'b1);
    chk("stag_valid0", outvalid, 0);
    pulse(4'b0010, 32'h44332211, 1'b1);
    chk("stag_valid1", outvalid, 0);
    pulse(4'b0100, 32'h44332211, 1'b1);
    chk("stag_valid2", outvalid, 0);
    pulse(4'b1000, 32'h44332211, 1'b1);
    chk("stag_valid3", outvalid, 1);
    wait_drained("stag");

    // Backpressure: row 0 must hold for 5 cycles
    outready = 1'b0;
    push(1'b0, 16'h6655, 1'b0);
    push(1'b1, 16'h8877, 1'b1);
    pulse(4'b1111, 32'h88776655, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", outvalid, 1);
      chk("bp_row", outrow, 0);
      chk("bp_value", outvalue, 16'h6655);
      tick();
    end
    outready = 1'b1;
    wait_drained("bp");
    repeat (3) tick();

    // Overflow: ena=0 repeat is ignored, ena=1 repeat is dropped
    push(1'b0, 16'hAA01, 1'b0);
    push(1'b1, 16'h0403, 1'b1);
    pulse(4'b0010, 32'h0000AA00, 1'b1);
    pulse(4'b0010, 32'h0000BB00, 1'b0);
    chk("ovf_ena0", overflow, 0);
    pulse(4'b0010, 32'h0000CC00, 1'b1);
    chk("ovf_set", overflow, 1);
    pulse(4'b1101, 32'h0403DD01, 1'b1);
    chk("ovf_valid", outvalid, 1);
    wait_drained("ovf");
    chk("ovf_sticky", overflow, 1);

    // Collision: PE2 pulses on the final handshake edge
    push(1'b0, 16'h1211, 1'b0);
    push(1'b1, 16'h1413, 1'b1);
    pulse(4'b1111, 32'h14131211, 1'b1);
    tick();
    resultvalid = 4'b0100;
    resultvalue = 32'h00550000;
    tick();
    resultvalid = '0;
    chk("coll_idle", outvalid, 0);
    chk("coll_drained", exp_q.size(), 0);
    push(1'b0, 16'h6261, 1'b0);
    push(1'b1, 16'h6455, 1'b1);
    pulse(4'b0011, 32'h64EE6261, 1'b1);
    chk("coll_partial", outvalid, 0);
    pulse(4'b1000, 32'h64EE6261, 1'b1);
    chk("coll_valid", outvalid, 1);
    wait_drained("coll");

    // Async reset mid-DRAIN
    outready = 1'b0;
    pulse(4'b1111, 32'hA4A3A2A1, 1'b1);
    chk("ar_pre_valid", outvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", outvalid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_overflow", overflow, 0);
    chk("ar_outrow", outrow, 0);
    #2;
    rst = 1'b1;
    tick();
    outready = 1'b1;
    repeat (2) tick();
    chk("ar_no_beat", outvalid, 0);
    push(1'b0, 16'hB2B1, 1'b0);
    push(1'b1, 16'hB4B3, 1'b1);
    pulse(4'b0001, 32'hB4B3B2B1, 1'b1);
    chk("ar_c1", outvalid, 0);
    pulse(4'b0010, 32'hB4B3B2B1, 1'b1);
    chk("ar_c2", outvalid, 0);
    pulse(4'b0100, 32'hB4B3B2B1, 1'b1);
    chk("ar_c3", outvalid, 0);
    pulse(4'b1000, 32'hB4B3B2B1, 1'b1);
    chk("ar_c4", outvalid, 1);
    wait_drained("ar");
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
